sram_controller: RTL

Memory-stage initiator that carries the pipeline's 32-bit word loads and stores to a 16-bit external SRAM. It splits each access into two half-word SRAM cycles plus a programmable settle interval, and holds `ready` low so the pipeline freezes until the access completes. It uses the same address map as the on-chip data memory (`(address - BASE_ADDR) >> 2`), so it is a drop-in replacement for that memory in the MEM stage.

---
 rtl/sram_controller_if.sv | 22 ++
 rtl/sram_controller.sv | 62 ++++++
 2 files changed

// File: rtl/sram_controller_if.sv
// sram_controller_if: pipeline MEM-stage request bus plus external 16-bit SRAM pins
interface sram_controller_if;
   logic        rd_en;
   logic        wr_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out;
   logic        sram_dq_oe;
   logic [15:0] sram_dq_in;
   logic        sram_we_n;
   modport master (
      output rd_en, wr_en, address, write_data, sram_dq_in,
      input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
   );
   modport slave (
      input  rd_en, wr_en, address, write_data, sram_dq_in,
      output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
   );
endinterface

// File: rtl/sram_controller.sv
// sram_controller: splits 32-bit pipeline loads/stores into two 16-bit SRAM cycles plus a settle interval
module sram_controller #(
   parameter logic [31:0] BASE_ADDR   = 32'd1024,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input logic clk,
   input logic rst,
   sram_controller_if.slave bus
);
   typedef enum logic [2:0] {IDLE, LOW, HIGH, WAIT, DONE} state_t;
   state_t      state;
   logic        wr;
   logic [15:0] wdata_hi;
   logic [3:0]  cnt;
   logic [16:0] idx;
   logic        req;
   assign req       = bus.rd_en | bus.wr_en;
   assign idx       = 17'((bus.address - BASE_ADDR) >> 2);
   assign bus.ready = (state == IDLE) ? ~req : (state == DONE);
   // SRAM pins are registered one state ahead so they are valid throughout LOW and HIGH
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state           <= IDLE;
         wr              <= 1'b0;
         wdata_hi        <= '0;
         cnt             <= '0;
         bus.read_data   <= '0;
         bus.sram_addr   <= '0;
         bus.sram_dq_out <= '0;
         bus.sram_dq_oe  <= 1'b0;
         bus.sram_we_n   <= 1'b1;
      end else
         case (state)
            IDLE: if (req) begin
               state           <= LOW;
               wr              <= bus.wr_en;
               wdata_hi        <= bus.write_data[31:16];
               bus.sram_addr   <= {idx, 1'b0};
               bus.sram_dq_out <= bus.write_data[15:0];
               bus.sram_we_n   <= ~bus.wr_en;
               bus.sram_dq_oe  <= bus.wr_en;
            end
            LOW: begin
               state            <= HIGH;
               bus.sram_addr[0] <= 1'b1;
               if (wr) bus.sram_dq_out <= wdata_hi;
               else bus.read_data[15:0] <= bus.sram_dq_in;
            end
            HIGH: begin
               state          <= (WAIT_CYCLES > 0) ? WAIT : DONE;
               cnt            <= 4'(WAIT_CYCLES - 1);
               bus.sram_we_n  <= 1'b1;
               bus.sram_dq_oe <= 1'b0;
               if (!wr) bus.read_data[31:16] <= bus.sram_dq_in;
            end
            WAIT: begin
               state <= (cnt == 4'd0) ? DONE : WAIT;
               cnt   <= (cnt == 4'd0) ? cnt : cnt - 4'd1;
            end
            default: state <= IDLE;
         endcase
endmodule
